path_pred_train_sched: RTL

//  Controller for the path-history tagged predictor. Owns speculative and committed path-history registers.

---
 rtl/path_pred_train_sched_if.sv | 47 ++++
 rtl/path_pred_train_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/path_pred_train_sched_if.sv
// Bundles the fetch, resolve and training ports of the path-history
// predictor controller. The slave modport is the controller's view; the
// master modport is the view of the fetch/resolve logic driving it.
interface path_pred_train_sched_if #(
   parameter int PATH_LEN = 4,
   parameter int CNT_BITS = 4
);
   localparam int PW = PATH_LEN * 32;

   logic          fetch_valid;
   logic          fetch_is_branch;
   logic [31:0]   fetch_pc;
   logic          fetch_pred_taken;
   logic          predict_en;
   logic [PW-1:0] spec_path;

   logic          resolve_valid;
   logic          resolve_ready;
   logic [31:0]   resolve_pc;
   logic          resolve_taken;
   logic          resolve_mispred;

   logic          flush;
   logic          train_hold;

   logic                train_en;
   logic [31:0]         train_pc;
   logic [PW-1:0]       train_path;
   logic                train_taken;
   logic [CNT_BITS-1:0] fifo_count;

   modport master (
      output fetch_valid, fetch_is_branch, fetch_pc, fetch_pred_taken,
      output resolve_valid, resolve_pc, resolve_taken, resolve_mispred,
      output flush, train_hold,
      input  predict_en, spec_path, resolve_ready,
      input  train_en, train_pc, train_path, train_taken, fifo_count
   );

   modport slave (
      input  fetch_valid, fetch_is_branch, fetch_pc, fetch_pred_taken,
      input  resolve_valid, resolve_pc, resolve_taken, resolve_mispred,
      input  flush, train_hold,
      output predict_en, spec_path, resolve_ready,
      output train_en, train_pc, train_path, train_taken, fifo_count
   );
endinterface

// File: rtl/path_pred_train_sched.sv
// Path-history predictor controller: keeps speculative and committed
// taken-branch path histories, queues resolved branches in a training FIFO
// and paces them onto the predictor's single train port.
//
// state | meaning
// IDLE  | no pulse in flight; pops the FIFO head when non-empty and not held
// ISSUE | train_en high this cycle; with no gap it may pop again at once
// GAP   | idle spacing after a pulse; pop-eligible again once counter is 0
module path_pred_train_sched #(
   parameter int PATH_LEN   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_BITS   = 4,
   parameter int TRAIN_GAP  = 1
) (
   input logic                    clk,
   input logic                    rst,
   path_pred_train_sched_if.slave bus
);
   localparam int PW    = PATH_LEN * 32;
   localparam int EW    = 32 + PW + 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int GAP_W = (TRAIN_GAP > 1) ? $clog2(TRAIN_GAP) : 1;

   // The GAP state is pop-eligible in its last cycle, so loading GAP-1
   // yields exactly TRAIN_GAP idle cycles between consecutive pulses.
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((TRAIN_GAP > 0) ? (TRAIN_GAP - 1) : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

   logic [PW-1:0]       spec_q, spec_d;
   logic [PW-1:0]       comm_q, comm_d;

   logic [EW-1:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0] count_q, count_d;

   logic                train_en_q, train_en_d;
   logic [31:0]         train_pc_q, train_pc_d;
   logic [PW-1:0]       train_path_q, train_path_d;
   logic                train_taken_q, train_taken_d;

   logic                predict_en;
   logic                ready;
   logic                acc;
   logic                recover;
   logic                fetch_upd;
   logic                can_pop;
   logic                eval_pop;
   logic                pop;

   // Shift a new most-recent PC into entry 0; the oldest entry falls off.
   function automatic logic [PW-1:0] shift_in(input logic [PW-1:0] path,
                                             input logic [31:0]   pc);
      shift_in = (path << 32) | PW'(pc);
   endfunction

   assign predict_en = bus.fetch_valid & bus.fetch_is_branch;
   assign ready      = (count_q < CNT_BITS'(FIFO_DEPTH)) & ~bus.flush;
   assign acc        = bus.resolve_valid & ready & ~bus.flush;
   assign recover    = acc & bus.resolve_mispred;
   assign fetch_upd  = predict_en & bus.fetch_pred_taken & ~bus.flush & ~recover;
   assign can_pop    = (count_q != '0) & ~bus.train_hold & ~bus.flush;

   assign bus.predict_en    = predict_en;
   assign bus.spec_path     = spec_q;
   assign bus.resolve_ready = ready;
   assign bus.train_en      = train_en_q;
   assign bus.train_pc      = train_pc_q;
   assign bus.train_path    = train_path_q;
   assign bus.train_taken   = train_taken_q;
   assign bus.fifo_count    = count_q;

   // Next committed history from accepted taken branches; speculative
   // history restored on flush/mispredict, otherwise advanced by fetch.
   always_comb begin
      comm_d = comm_q;
      if (acc && bus.resolve_taken) begin
         comm_d = shift_in(comm_q, bus.resolve_pc);
      end
      spec_d = spec_q;
      if (bus.flush) begin
         spec_d = comm_q;
      end else if (recover) begin
         spec_d = comm_d;
      end else if (fetch_upd) begin
         spec_d = shift_in(spec_q, bus.fetch_pc);
      end
   end

   // Train scheduler next-state: decides when the FIFO head is popped.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      eval_pop  = 1'b0;
      pop       = 1'b0;
      unique case (state_q)
         IDLE: begin
            eval_pop = 1'b1;
         end
         ISSUE: begin
            if (TRAIN_GAP > 0) begin
               state_d   = GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               eval_pop = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               eval_pop = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (eval_pop) begin
         if (can_pop) begin
            pop     = 1'b1;
            state_d = ISSUE;
         end else begin
            state_d = IDLE;
         end
      end
      if (bus.flush) begin
         pop     = 1'b0;
         state_d = IDLE;
      end
   end

   // FIFO pointer/occupancy update; a flush empties the queue outright.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(acc);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_BITS'(acc) - CNT_BITS'(pop);
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Train port outputs load from the FIFO head on a pop and hold otherwise.
   always_comb begin
      train_en_d    = pop;
      train_pc_d    = train_pc_q;
      train_path_d  = train_path_q;
      train_taken_d = train_taken_q;
      if (pop) begin
         {train_pc_d, train_path_d, train_taken_d} = mem_q[rd_ptr_q];
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (acc) begin
         mem_q[wr_ptr_q] <= {bus.resolve_pc, comm_q, bus.resolve_taken};
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         gap_cnt_q     <= '0;
         spec_q        <= '0;
         comm_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         train_en_q    <= 1'b0;
         train_pc_q    <= '0;
         train_path_q  <= '0;
         train_taken_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         gap_cnt_q     <= gap_cnt_d;
         spec_q        <= spec_d;
         comm_q        <= comm_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         train_en_q    <= train_en_d;
         train_pc_q    <= train_pc_d;
         train_path_q  <= train_path_d;
         train_taken_q <= train_taken_d;
      end
   end
endmodule
